// File: rtl/subservient_sram_arbiter.sv
// Shares one byte-wide SRAM between the RF port (absolute priority) and two
// 32-bit Wishbone masters, serialising each word access into four byte slots.
module subservient_sram_arbiter #(
  parameter int memsize = 512,
  parameter int aw      = $clog2(memsize)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [aw-1:0]   i_rf_waddr,
  input  logic [7:0]      i_rf_wdata,
  input  logic            i_rf_wen,
  input  logic [aw-1:0]   i_rf_raddr,
  input  logic            i_rf_ren,
  output logic [7:0]      o_rf_rdata,
  input  logic [31:0]     i_wb0_adr,
  input  logic [31:0]     i_wb0_dat,
  input  logic [3:0]      i_wb0_sel,
  input  logic            i_wb0_we,
  input  logic            i_wb0_stb,
  output logic [31:0]     o_wb0_rdt,
  output logic            o_wb0_ack,
  input  logic [31:0]     i_wb1_adr,
  input  logic [31:0]     i_wb1_dat,
  input  logic [3:0]      i_wb1_sel,
  input  logic            i_wb1_we,
  input  logic            i_wb1_stb,
  output logic [31:0]     o_wb1_rdt,
  output logic            o_wb1_ack,
  output logic [aw-1:0]   o_sram_waddr,
  output logic [7:0]      o_sram_wdata,
  output logic            o_sram_wen,
  output logic [aw-1:0]   o_sram_raddr,
  input  logic [7:0]      i_sram_rdata,
  output logic            o_sram_ren
);

  localparam int unsigned word_aw = aw - 2;

  typedef enum logic [2:0] {IDLE, WRITE, READ, RDONE, ACK} state_t;

  state_t               state, state_next;
  logic [1:0]           cnt, cnt_next;
  logic                 grant;
  logic                 last_grant;
  logic [word_aw-1:0]   adr_q;
  logic [31:0]          dat_q;
  logic [3:0]           sel_q;
  logic                 pend, pend_next;
  logic [1:0]           pend_idx;
  logic [31:0]          rdt0_q, rdt1_q;
  logic                 ack0_q, ack1_q;

  logic                 take;
  logic                 gnt_sel;
  logic                 eng_wen;
  logic                 eng_ren;
  logic [aw-1:0]        eng_addr;
  logic [7:0]           eng_wbyte;

  // Address bits outside the SRAM word range are intentionally ignored
  logic unused_adr_bits;
  assign unused_adr_bits = ^{i_wb0_adr[31:aw], i_wb0_adr[1:0],
                             i_wb1_adr[31:aw], i_wb1_adr[1:0]};

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state, arbitration and engine strobes
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    take       = 1'b0;
    gnt_sel    = 1'b0;
    eng_wen    = 1'b0;
    eng_ren    = 1'b0;
    pend_next  = 1'b0;
    case (state)
      IDLE: begin
        if (i_wb0_stb || i_wb1_stb) begin
          take       = 1'b1;
          gnt_sel    = (i_wb0_stb && i_wb1_stb) ? ~last_grant : i_wb1_stb;
          cnt_next   = 2'd0;
          state_next = (gnt_sel ? i_wb1_we : i_wb0_we) ? WRITE : READ;
        end
      end
      WRITE: begin
        if (!i_rf_wen) begin
          eng_wen  = sel_q[cnt];
          cnt_next = cnt + 2'd1;
          if (cnt == 2'd3) state_next = ACK;
        end
      end
      READ: begin
        if (!i_rf_ren) begin
          eng_ren   = 1'b1;
          pend_next = 1'b1;
          cnt_next  = cnt + 2'd1;
          if (cnt == 2'd3) state_next = RDONE;
        end
      end
      RDONE:   state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction latches, read assembly and acknowledges
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt        <= 2'd0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      pend       <= 1'b0;
      pend_idx   <= 2'd0;
      rdt0_q     <= '0;
      rdt1_q     <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      pend     <= pend_next;
      pend_idx <= cnt;
      if (take) begin
        grant      <= gnt_sel;
        last_grant <= gnt_sel;
        adr_q      <= gnt_sel ? i_wb1_adr[aw-1:2] : i_wb0_adr[aw-1:2];
        dat_q      <= gnt_sel ? i_wb1_dat : i_wb0_dat;
        sel_q      <= gnt_sel ? i_wb1_sel : i_wb0_sel;
      end
      if (pend) begin
        if (grant) rdt1_q[{pend_idx, 3'b000} +: 8] <= i_sram_rdata;
        else       rdt0_q[{pend_idx, 3'b000} +: 8] <= i_sram_rdata;
      end
      ack0_q <= (state_next == ACK) && (state != ACK) && !grant;
      ack1_q <= (state_next == ACK) && (state != ACK) && grant;
    end
  end

  // SRAM port muxing: RF owns whichever port it is using this cycle
  assign eng_addr     = {adr_q, cnt};
  assign eng_wbyte    = 8'(dat_q >> {cnt, 3'b000});
  assign o_sram_waddr = i_rf_wen ? i_rf_waddr : eng_addr;
  assign o_sram_wdata = i_rf_wen ? i_rf_wdata : eng_wbyte;
  assign o_sram_wen   = i_rf_wen | eng_wen;
  assign o_sram_raddr = i_rf_ren ? i_rf_raddr : eng_addr;
  assign o_sram_ren   = i_rf_ren | eng_ren;
  assign o_rf_rdata   = i_sram_rdata;

  assign o_wb0_rdt = rdt0_q;
  assign o_wb1_rdt = rdt1_q;
  assign o_wb0_ack = ack0_q;
  assign o_wb1_ack = ack1_q;

endmodule
